// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer and the controller that
// drives it. Holds the 3-bit flow-control opcode encoding; any code outside the
// listed values is treated as OP_NEXT by the sequencer.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NEXT = 3'b000;  // pc <- pc + 1
  localparam logic [OP_W-1:0] OP_BR   = 3'b001;  // conditional relative branch
  localparam logic [OP_W-1:0] OP_JMP  = 3'b010;  // absolute jump
  localparam logic [OP_W-1:0] OP_CALL = 3'b011;  // push return address, jump
  localparam logic [OP_W-1:0] OP_RET  = 3'b100;  // pop return address

endpackage : pc_seq_pkg

// File: rtl/ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// Return-address LIFO for the PC sequencer. Storage is a register array
// addressed by the occupancy count; the top entry is read combinationally so a
// return can redirect the PC in the same cycle it is requested.
//
// Parameters: W (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset (clears occupancy only)
//   push   in   write din on top (ignored when full)
//   pop    in   remove top entry (ignored when empty); never with push
//   din    in   W      value to push
//   top    out  W      current top entry (undefined when empty)
//   depth  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//   full   out  depth == DEPTH
//   empty  out  depth == 0
// -----------------------------------------------------------------------------
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;

  // Slot index is the low bits of the count; when full no write happens, so
  // dropping the MSB never aliases a live entry.
  assign wr_idx  = depth_q[IW-1:0];
  assign top_idx = IW'(depth_q - 1'b1);
  assign top     = mem_q[top_idx];
  assign do_push = push && !full;

  // NOTE: default assigned first so every path drives depth_d; without it an
  // idle cycle would infer a latch instead of holding the register.
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // NOTE: the entry array is deliberately left out of reset; occupancy alone
  // defines validity, and keeping reset off the array lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule : ret_stack

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the single-cycle core. Holds the PC, selects
// the next fetch address for sequential / branch / jump / call / return flow,
// and owns the return-address stack (ret_stack).
//
// Optional feature macro: PC_SEQ_TRAP_EN
//   Defined   : stack overflow/underflow sets a sticky fault and vectors the
//               PC to TRAP_PC; while faulted every non-stalled op yields
//               TRAP_PC and the stack is frozen until reset.
//   Undefined : fault tied low; overflow drops the push, underflow falls
//               through to pc + 1.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset (overrides stall and op)
//   stall   in   hold PC and stack, ignore op
//   op      in   3       flow opcode (pc_seq_pkg encoding)
//   cond    in   branch condition, used only by OP_BR
//   offset  in   OFF_W   signed relative-branch offset
//   target  in   ADDR_W  absolute JMP/CALL destination
//   pc      out  ADDR_W  registered fetch address
//   depth   out  stack occupancy 0..DEPTH
//   full    out  depth == DEPTH
//   empty   out  depth == 0
//   ovf     out  registered one-cycle pulse: CALL while full
//   unf     out  registered one-cycle pulse: RET while empty
//   fault   out  sticky trap flag
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                OFF_W    = 8,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_PC  = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [2:0]               op,
  input  logic                     cond,
  input  logic [OFF_W-1:0]         offset,
  input  logic [ADDR_W-1:0]        target,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf,
  output logic                     fault
);

`ifdef PC_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] pc1;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] stack_top;
  logic              push, pop;

  assign pc1   = pc_q + 1'b1;
  // Size-casting the signed offset sign-extends it; the add wraps modulo 2^ADDR_W.
  assign br_pc = pc1 + ADDR_W'(signed'(offset));

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc1),
    .top   (stack_top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    fault_d = fault_q;

    if (!stall) begin
      case (op)
        OP_BR:   pc_d = cond ? br_pc : pc1;
        OP_JMP:  pc_d = target;
        OP_CALL: begin
          pc_d = target;
          if (full) ovf_d = 1'b1;
          else      push  = 1'b1;
        end
        OP_RET: begin
          if (empty) begin
            pc_d  = pc1;
            unf_d = 1'b1;
          end else begin
            pc_d = stack_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc1;
      endcase

      // A new stack fault, or one already latched, overrides the normal flow
      // and freezes the stack.
      if (TRAP_EN && (fault_q || ovf_d || unf_d)) begin
        pc_d    = TRAP_PC;
        push    = 1'b0;
        pop     = 1'b0;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign fault = fault_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer at default parameters (ADDR_W=12, OFF_W=8,
// DEPTH=8, RESET_PC=0, TRAP_PC=0xFFF). Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, i.e. after the edge that consumed
// the op. The trap scenario is selected by PC_SEQ_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic        cond;
  logic [7:0]  offset;
  logic [11:0] target;
  logic [11:0] pc;
  logic [3:0]  depth;
  logic        full, empty, ovf, unf, fault;

  int checks   = 0;
  int failures = 0;

  logic [19:0] obs;
  assign obs = {pc, depth, full, empty, ovf, unf};

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .op     (op),
    .cond   (cond),
    .offset (offset),
    .target (target),
    .pc     (pc),
    .depth  (depth),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf),
    .fault  (fault)
  );

  // Expected observation vector; full/empty follow from the expected depth.
  function automatic logic [19:0] expv(input logic [11:0] p, input int d,
                                       input logic o, input logic u);
    return {p, 4'(d), (d == 8), (d == 0), o, u};
  endfunction

  // Present one op for one clock edge, then settle past the edge.
  task automatic drive(input logic [2:0] o, input logic c, input logic [7:0] off,
                       input logic [11:0] tgt, input logic st);
    op = o; cond = c; offset = off; target = tgt; stall = st;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(OP_CALL, 1'b1, 8'h00, 12'h123, 1'b0);
    drive(OP_CALL, 1'b1, 8'h00, 12'h123, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    apply_reset();
    e = expv(12'h000, 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL reset_state got=%h exp=%h", obs, e); failures++;
    end
    checks++;
    if (fault !== 1'b0) begin
      $display("FAIL reset_fault got=%b exp=0", fault); failures++;
    end
    for (int i = 1; i <= 3; i++) begin
      drive(OP_NEXT, 1'b0, 8'h00, 12'h000, 1'b0);
      e = expv(12'(i), 0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL next_%0d got=%h exp=%h", i, obs, e); failures++;
      end
    end
  endtask

  task automatic test_branch();
    // {op, cond, offset, target, expected pc}; stack stays empty throughout.
    logic [2:0]  v_op  [10] = '{OP_JMP, OP_BR, OP_JMP, OP_BR, OP_JMP, OP_NEXT,
                                OP_JMP, OP_BR, 3'b110, OP_BR};
    logic        v_c   [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [7:0]  v_off [10] = '{8'h00, 8'hFC, 8'h00, 8'hFC, 8'h00, 8'h00,
                                8'h00, 8'h03, 8'h00, 8'h80};
    logic [11:0] v_tgt [10] = '{12'h010, 12'h555, 12'h010, 12'h555, 12'hFFF,
                                12'h000, 12'hFFE, 12'h000, 12'h777, 12'h000};
    logic [11:0] v_exp [10] = '{12'h010, 12'h00D, 12'h010, 12'h011, 12'hFFF,
                                12'h000, 12'hFFE, 12'h002, 12'h003, 12'hF84};
    logic [19:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(v_op[i], v_c[i], v_off[i], v_tgt[i], 1'b0);
      e = expv(v_exp[i], 0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL branch_%0d got=%h exp=%h", i, obs, e); failures++;
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  v_op  [4] = '{OP_JMP, OP_CALL, OP_NEXT, OP_RET};
    logic [11:0] v_tgt [4] = '{12'h020, 12'h100, 12'h000, 12'h000};
    logic [11:0] v_exp [4] = '{12'h020, 12'h100, 12'h101, 12'h021};
    int          v_d   [4] = '{0, 1, 1, 0};
    logic [19:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(v_op[i], 1'b0, 8'h00, v_tgt[i], 1'b0);
      e = expv(v_exp[i], v_d[i], 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL call_ret_%0d got=%h exp=%h", i, obs, e); failures++;
      end
    end
  endtask

  task automatic test_nested();
    logic [11:0] model [$];
    logic [11:0] cur;
    logic [11:0] tgt;
    logic [19:0] e;
    drive(OP_JMP, 1'b0, 8'h00, 12'h200, 1'b0);
    cur = 12'h200;
    for (int k = 0; k < 8; k++) begin
      tgt = 12'(12'h300 + k * 16);
      model.push_back(12'(cur + 1));
      drive(OP_CALL, 1'b0, 8'h00, tgt, 1'b0);
      cur = tgt;
      e = expv(cur, k + 1, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL nest_call_%0d got=%h exp=%h", k, obs, e); failures++;
      end
    end
    // Ninth call on a full stack.
    drive(OP_CALL, 1'b0, 8'h00, 12'h380, 1'b0);
`ifdef PC_SEQ_TRAP_EN
    e = expv(12'hFFF, 8, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL nest_ovf_trap got=%h exp=%h", obs, e); failures++;
    end
    apply_reset();
`else
    e = expv(12'h380, 8, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL nest_ovf got=%h exp=%h", obs, e); failures++;
    end
    for (int j = 0; j < 8; j++) begin
      cur = model.pop_back();
      drive(OP_RET, 1'b0, 8'h00, 12'h000, 1'b0);
      e = expv(cur, 7 - j, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL nest_ret_%0d got=%h exp=%h", j, obs, e); failures++;
      end
    end
    // Ninth return on an empty stack falls through to pc + 1.
    drive(OP_RET, 1'b0, 8'h00, 12'h000, 1'b0);
    e = expv(12'(cur + 1), 0, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin
      $display("FAIL nest_unf got=%h exp=%h", obs, e); failures++;
    end
    drive(OP_NEXT, 1'b0, 8'h00, 12'h000, 1'b0);
    e = expv(12'(cur + 2), 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL nest_unf_clear got=%h exp=%h", obs, e); failures++;
    end
`endif
  endtask

  task automatic test_stall();
    logic [19:0] e;
    drive(OP_JMP, 1'b0, 8'h00, 12'h040, 1'b0);
    drive(OP_CALL, 1'b0, 8'h00, 12'h080, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(OP_CALL, 1'b0, 8'h00, 12'h0F0, 1'b1);
      e = expv(12'h080, 1, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
        $display("FAIL stall_call_%0d got=%h exp=%h", i, obs, e); failures++;
      end
    end
    drive(OP_RET, 1'b0, 8'h00, 12'h000, 1'b1);
    e = expv(12'h080, 1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL stall_ret got=%h exp=%h", obs, e); failures++;
    end
    drive(OP_NEXT, 1'b0, 8'h00, 12'h000, 1'b0);
    e = expv(12'h081, 1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL stall_release got=%h exp=%h", obs, e); failures++;
    end
    for (int i = 0; i < 4; i++) drive(OP_CALL, 1'b0, 8'h00, 12'(12'h0A0 + i), 1'b0);
    e = expv(12'h0A3, 5, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL stall_depth5 got=%h exp=%h", obs, e); failures++;
    end
    // Reset while stalled with five pending return addresses.
    reset = 1'b0;
    drive(OP_CALL, 1'b0, 8'h00, 12'h0F0, 1'b1);
    reset = 1'b1;
    e = expv(12'h000, 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      $display("FAIL stall_reset got=%h exp=%h", obs, e); failures++;
    end
    // The discarded addresses must not come back: RET now underflows.
    drive(OP_NEXT, 1'b0, 8'h00, 12'h000, 1'b0);
    drive(OP_RET, 1'b0, 8'h00, 12'h000, 1'b0);
`ifdef PC_SEQ_TRAP_EN
    e = expv(12'hFFF, 0, 1'b0, 1'b1);
`else
    e = expv(12'h002, 0, 1'b0, 1'b1);
`endif
    checks++;
    if (obs !== e) begin
      $display("FAIL reset_discard got=%h exp=%h", obs, e); failures++;
    end
    apply_reset();
  endtask

  task automatic test_trap();
    logic [19:0] e;
    apply_reset();
    drive(OP_RET, 1'b0, 8'h00, 12'h000, 1'b0);
`ifdef PC_SEQ_TRAP_EN
    e = expv(12'hFFF, 0, 1'b0, 1'b1);
    checks++;
    if (obs !== e || fault !== 1'b1) begin
      $display("FAIL trap_enter got=%h fault=%b exp=%h fault=1", obs, fault, e); failures++;
    end
    drive(OP_JMP, 1'b0, 8'h00, 12'h050, 1'b0);
    e = expv(12'hFFF, 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e || fault !== 1'b1) begin
      $display("FAIL trap_jmp got=%h fault=%b exp=%h fault=1", obs, fault, e); failures++;
    end
    drive(OP_CALL, 1'b0, 8'h00, 12'h060, 1'b0);
    checks++;
    if (obs !== e || fault !== 1'b1) begin
      $display("FAIL trap_call got=%h fault=%b exp=%h fault=1", obs, fault, e); failures++;
    end
    apply_reset();
    e = expv(12'h000, 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e || fault !== 1'b0) begin
      $display("FAIL trap_reset got=%h fault=%b exp=%h fault=0", obs, fault, e); failures++;
    end
`else
    e = expv(12'h001, 0, 1'b0, 1'b1);
    checks++;
    if (obs !== e || fault !== 1'b0) begin
      $display("FAIL notrap_unf got=%h fault=%b exp=%h fault=0", obs, fault, e); failures++;
    end
    drive(OP_JMP, 1'b0, 8'h00, 12'h050, 1'b0);
    e = expv(12'h050, 0, 1'b0, 1'b0);
    checks++;
    if (obs !== e || fault !== 1'b0) begin
      $display("FAIL notrap_jmp got=%h fault=%b exp=%h fault=0", obs, fault, e); failures++;
    end
`endif
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; op = OP_NEXT; cond = 1'b0;
    offset = '0; target = '0;
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_call_ret();
    test_nested();
    test_stall();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core. Holds the PC, computes the next fetch address for sequential, relative-branch, absolute-jump, call and return flow, and owns the return-address stack. Replaces the fixed 12-bit PC logic and the unchecked stack with configurable widths and depth, a stall hold, conditional branching, signed offsets, and overflow/underflow detection. Sits between the controller (which supplies `op`) and the instruction memory (which receives `pc`).

## Interface
- `ADDR_W`, 12, PC / return-address width
- `OFF_W`, 8, signed relative-branch offset width (`OFF_W <= ADDR_W`)
- `DEPTH`, 8, return-stack entries (power of two, ≥ 2)
- `RESET_PC`, 0, PC value after reset
- `TRAP_PC`, 2^ADDR_W−1, fault vector (used only with `PC_SEQ_TRAP_EN`)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets all state
- `stall`  in  1  1 = hold PC and stack, ignore `op`
- `op`  in  3  000 NEXT, 001 BR (relative, conditional), 010 JMP, 011 CALL, 100 RET; 101–111 treated as NEXT
- `cond`  in  1  branch condition, sampled only for BR
- `offset`  in  OFF_W  signed two's-complement branch offset
- `target`  in  ADDR_W  absolute JMP/CALL destination
- `pc`  out  ADDR_W  current fetch address (registered)
- `depth`  out  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH
- `full`, `empty`  out  1  `depth==DEPTH` / `depth==0`
- `ovf`, `unf`  out  1  one-cycle pulses: CALL on full / RET on empty
- `fault`  out  1  sticky trap flag (0 when `PC_SEQ_TRAP_EN` undefined)

## Operation
- `pc1 = pc + 1`, modulo 2^ADDR_W (all-ones wraps to 0).
- NEXT: `pc ← pc1`.
- BR: `cond=1` → `pc ← pc1 + sext(offset)` modulo 2^ADDR_W; `cond=0` → `pc ← pc1`.
- JMP: `pc ← target`.
- CALL: push `pc1`; `pc ← target`. If `full`: push discarded, stack unchanged, `ovf` pulses, `pc ← target`.
- RET: `pc ← top`, pop. If `empty`: `pc ← pc1`, `unf` pulses, stack unchanged.
- `stall=1`: pc, stack, depth frozen; `ovf`/`unf` = 0; `op` ignored.
- Flags use pre-edge `depth`; `full`/`empty` are combinational from registered `depth`.

## Timing
- `pc` registered; next PC combinational from `op`/`cond`/`offset`/`target`; new PC visible the cycle after `op` is presented.
- Push and pop take effect on the same edge as the PC update; RET reads the top entry combinationally (zero-latency top-of-stack).
- `ovf`/`unf` registered, high exactly one cycle after the offending edge.
- Reset (`reset=0` at edge, overrides `stall` and `op`): `pc=RESET_PC`, `depth=0`, `full=0`, `empty=1`, `ovf=unf=0`, `fault=0`. Stack RAM contents need not be cleared. Reset mid-call-sequence discards all pending return addresses.
- No combinational path from `op` to `pc`, `depth`, or flags.

## Configuration
- `PC_SEQ_TRAP_EN` defined: ovf or unf condition additionally sets sticky `fault` and forces `pc ← TRAP_PC` instead of the normal next PC; while `fault=1`, every non-stalled op yields `pc ← TRAP_PC` and the stack is frozen; only reset clears it.
- Undefined: `fault` tied 0; ovf/unf follow the non-trapping rules above.

## Structure
- `pc_seq_pkg`: op encoding constants (`OP_NEXT`, `OP_BR`, `OP_JMP`, `OP_CALL`, `OP_RET`) shared with the controller.
- One sub-module `ret_stack` (params `W`, `DEPTH`): push/pop/hold, `top`, `depth`, registered storage with pointer; push+pop never asserted together.
- `pc_sequencer` holds next-PC mux, PC register, flag/fault logic.

## Test plan
- Reset then 3× NEXT with ADDR_W=12 → pc 0,1,2,3; `empty=1`, `depth=0`.
- pc=0x010, BR offset=0xFC (−4), cond=1 → pc=0x00D; same with cond=0 → pc=0x011; pc=0xFFF NEXT → 0x000.
- pc=0x020 CALL target=0x100, then NEXT, RET → pc 0x100, 0x101, 0x021; depth 0→1→1→0.
- DEPTH=8: 9 nested CALLs → 9th pulses `ovf`, depth stays 8; 8 RETs return last 8 addresses in LIFO order; 9th RET pulses `unf`, pc=pc1.
- `stall=1` for 3 cycles during CALL → pc and depth unchanged; `reset=0` while stall=1 and depth=5 → pc=RESET_PC, depth=0.
- `PC_SEQ_TRAP_EN`, RET on empty → `fault=1`, pc=TRAP_PC; subsequent JMP 0x050 → pc stays TRAP_PC until reset.
